// File: rtl/riscv_mem_arbiter.sv
// Two-requester arbiter for the block-wide main-memory port (dcache refill/writeback, icache refill).
// Define RISCV_MEMARB_RR_EN to use round-robin instead of fixed dcache priority on simultaneous requests.
`timescale 1ns/1ps
module riscv_mem_arbiter #(
  parameter int DATA_WIDTH = 128,
  parameter int S_ADDR     = 23,
  parameter int TIMEOUT    = 1023
) (
  input  logic                  i_riscv_memarb_clk,
  input  logic                  i_riscv_memarb_rst_n,
  input  logic                  i_riscv_memarb_dc_rden,
  input  logic                  i_riscv_memarb_dc_wren,
  input  logic [S_ADDR-1:0]     i_riscv_memarb_dc_addr,
  input  logic [DATA_WIDTH-1:0] i_riscv_memarb_dc_wdata,
  output logic                  o_riscv_memarb_dc_ready,
  output logic [DATA_WIDTH-1:0] o_riscv_memarb_dc_rdata,
  input  logic                  i_riscv_memarb_ic_rden,
  input  logic [S_ADDR-1:0]     i_riscv_memarb_ic_addr,
  output logic                  o_riscv_memarb_ic_ready,
  output logic [DATA_WIDTH-1:0] o_riscv_memarb_ic_rdata,
  output logic                  o_riscv_memarb_mem_rden,
  output logic                  o_riscv_memarb_mem_wren,
  output logic [S_ADDR-1:0]     o_riscv_memarb_mem_addr,
  output logic [DATA_WIDTH-1:0] o_riscv_memarb_mem_wdata,
  input  logic                  i_riscv_memarb_mem_ready,
  input  logic [DATA_WIDTH-1:0] i_riscv_memarb_mem_rdata,
  output logic                  o_riscv_memarb_timeout_err
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GNT_DC, GNT_IC, DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [S_ADDR-1:0]     r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_op_wr;
  logic [CW-1:0]         r_cnt;
  logic                  r_err;

  logic w_dc_req, w_ic_req, w_pick_dc, w_cap, w_gnt, w_wait;
  logic w_dc_ready, w_ic_ready;

  assign w_dc_req = i_riscv_memarb_dc_rden | i_riscv_memarb_dc_wren;
  assign w_ic_req = i_riscv_memarb_ic_rden;
  assign w_cap    = (r_state == IDLE) & (w_dc_req | w_ic_req);
  assign w_gnt    = (r_state == GNT_DC) | (r_state == GNT_IC);
  assign w_wait   = w_gnt & ~i_riscv_memarb_mem_ready;

`ifdef RISCV_MEMARB_RR_EN
  // r_last_owner: 1 = icache was granted last, so dcache wins the next tie.
  logic r_last_owner;
  assign w_pick_dc = w_dc_req & (~w_ic_req | r_last_owner);

  always_ff @(posedge i_riscv_memarb_clk or negedge i_riscv_memarb_rst_n) begin
    if (!i_riscv_memarb_rst_n) r_last_owner <= 1'b1;
    else if (w_cap)            r_last_owner <= ~w_pick_dc;
  end
`else
  assign w_pick_dc = w_dc_req;
`endif

  always_ff @(posedge i_riscv_memarb_clk or negedge i_riscv_memarb_rst_n) begin
    if (!i_riscv_memarb_rst_n) r_state <= IDLE;
    else                       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dc_ready  = 1'b0;
    w_ic_ready  = 1'b0;
    case (r_state)
      IDLE:   if (w_dc_req | w_ic_req) w_state_nxt = w_pick_dc ? GNT_DC : GNT_IC;
      GNT_DC: if (i_riscv_memarb_mem_ready) begin
                w_dc_ready  = 1'b1;
                w_state_nxt = DONE;
              end
      GNT_IC: if (i_riscv_memarb_mem_ready) begin
                w_ic_ready  = 1'b1;
                w_state_nxt = DONE;
              end
      // Request levels are ignored here so a stale level cannot re-grant.
      DONE:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Write wins when the dcache raises both strobes; its read is a later grant.
  always_ff @(posedge i_riscv_memarb_clk or negedge i_riscv_memarb_rst_n) begin
    if (!i_riscv_memarb_rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_op_wr <= 1'b0;
    end else if (w_cap) begin
      r_addr  <= w_pick_dc ? i_riscv_memarb_dc_addr : i_riscv_memarb_ic_addr;
      r_op_wr <= w_pick_dc & i_riscv_memarb_dc_wren;
      r_wdata <= (w_pick_dc & i_riscv_memarb_dc_wren) ? i_riscv_memarb_dc_wdata : '0;
    end
  end

  // Saturating wait counter; the error flag sets on the edge the count reaches TIMEOUT.
  always_ff @(posedge i_riscv_memarb_clk or negedge i_riscv_memarb_rst_n) begin
    if (!i_riscv_memarb_rst_n) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_cap)
        r_cnt <= '0;
      else if (w_wait && (r_cnt != CW'(TIMEOUT)))
        r_cnt <= r_cnt + 1'b1;
      if (w_wait && (r_cnt != CW'(TIMEOUT)) && ((r_cnt + 1'b1) == CW'(TIMEOUT)))
        r_err <= 1'b1;
    end
  end

  assign o_riscv_memarb_mem_rden    = w_gnt & ~r_op_wr;
  assign o_riscv_memarb_mem_wren    = w_gnt &  r_op_wr;
  assign o_riscv_memarb_mem_addr    = w_gnt ? r_addr : '0;
  assign o_riscv_memarb_mem_wdata   = (w_gnt & r_op_wr) ? r_wdata : '0;
  assign o_riscv_memarb_dc_ready    = w_dc_ready;
  assign o_riscv_memarb_ic_ready    = w_ic_ready;
  assign o_riscv_memarb_dc_rdata    = i_riscv_memarb_mem_rdata;
  assign o_riscv_memarb_ic_rdata    = i_riscv_memarb_mem_rdata;
  assign o_riscv_memarb_timeout_err = r_err;

endmodule
